// File: rtl/ucode_chk_pkg.sv
// Shared types and constants for the microcode checkpoint unit.
package ucode_chk_pkg;

    localparam int unsigned PCW_D  = 12;
    localparam int unsigned CNTW_D = 16;

    localparam logic [3:0] SQI_CONT = 4'd14;
    localparam logic [1:0] MAP_PE   = 2'd0;

    typedef enum logic [2:0] {
        RK_OFF  = 3'd0,
        RK_JUMP = 3'd1,
        RK_LOOP = 3'd2,
        RK_FAIL = 3'd3,
        RK_PASS = 3'd4
    } rule_kind_t;

    typedef struct packed {
        rule_kind_t         kind;
        logic [PCW_D-1:0]   from_pc;
        logic [PCW_D-1:0]   to_pc;
        logic [PCW_D-1:0]   target;
        logic [CNTW_D-1:0]  count;
    } rule_t;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_REDIR = 2'd1,
        ST_DONE  = 2'd2
    } chk_state_t;

    // Undefined kind codes collapse to OFF so they can never match.
    function automatic rule_kind_t decode_kind(input logic [2:0] k);
        return (k > 3'd4) ? RK_OFF : rule_kind_t'(k);
    endfunction

endpackage

// File: rtl/ucode_chk_rule.sv
// One rule slot: stored rule, loop counter, match and redirect address.
module ucode_chk_rule
    import ucode_chk_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  rule_t             wr_rule,
    input  logic [PCW_D-1:0]  pc_x,
    input  logic [PCW_D-1:0]  pc_f,
    input  logic              cont_pe,
    input  logic [PCW_D-1:0]  cont_addr,
    input  logic              loop_fire,
    output logic              match_c,
    output rule_kind_t        kind_c,
    output logic [PCW_D-1:0]  redir_c,
    output logic              last_c
);

    rule_t              rule_q;
    logic [CNTW_D-1:0]  cnt_q;
    logic [CNTW_D:0]    cnt_inc_c;

    // A write replaces the rule and restarts its loop count.
    always_ff @(posedge clk) begin
        if (reset) begin
            rule_q <= '0;
            cnt_q  <= '0;
        end else if (we) begin
            rule_q <= wr_rule;
            cnt_q  <= '0;
        end else if (loop_fire) begin
            cnt_q <= last_c ? '0 : cnt_inc_c[CNTW_D-1:0];
        end
    end

    // A count of 0 falls out as "last on first pass" since the new count is >= 1.
    assign cnt_inc_c = {1'b0, cnt_q} + (CNTW_D+1)'(1);
    assign last_c    = cnt_inc_c >= {1'b0, rule_q.count};
    assign kind_c    = rule_q.kind;
    assign redir_c   = (rule_q.kind == RK_LOOP) ? rule_q.from_pc : rule_q.target;

    always_comb begin
        match_c = 1'b0;
        unique case (rule_q.kind)
            RK_JUMP:          match_c = (pc_x == rule_q.from_pc) && (pc_f == rule_q.to_pc);
            RK_LOOP:          match_c = cont_pe && (cont_addr == rule_q.from_pc);
            RK_FAIL, RK_PASS: match_c = (pc_x == rule_q.from_pc);
            default:          match_c = 1'b0;
        endcase
    end

endmodule

// File: rtl/ucode_chk_unit.sv
// Table-driven microcode test checkpoint: rule priority, redirect FSM, cycle limit.
// Optional retire-PC history buffer enabled by defining UCODE_CHK_HIST_EN.
module ucode_chk_unit
    import ucode_chk_pkg::*;
#(
    parameter int unsigned PCW    = PCW_D,
    parameter int unsigned NRULES = 32,
    parameter int unsigned CNTW   = CNTW_D,
    parameter int unsigned LIMW   = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       retire,
    input  logic [PCW-1:0]             pc_x,
    input  logic [PCW-1:0]             pc_f,
    input  logic [112:1]               op_x,
    input  logic                       cfg_we,
    input  logic [$clog2(NRULES)-1:0]  cfg_idx,
    input  logic [2:0]                 cfg_kind,
    input  logic [PCW-1:0]             cfg_from,
    input  logic [PCW-1:0]             cfg_to,
    input  logic [PCW-1:0]             cfg_target,
    input  logic [CNTW-1:0]            cfg_count,
    input  logic [LIMW-1:0]            limit,
    output logic                       redir_valid,
    output logic [PCW-1:0]             redir_pc,
    input  logic                       redir_ready,
    output logic                       ev_valid,
    output logic [$clog2(NRULES)-1:0]  ev_rule,
    output logic [2:0]                 ev_kind,
    output logic                       done,
    output logic                       pass,
    output logic                       fail,
    output logic                       timeout,
    input  logic [2:0]                 hist_idx,
    output logic [PCW-1:0]             hist_pc
);

    localparam int unsigned IW = $clog2(NRULES);

    chk_state_t         state_q;
    logic [LIMW-1:0]    cyc_q;
    logic [LIMW-1:0]    cyc_next_c;
    logic               timeout_hit_c;
    logic               retire_run_c;
    logic               cont_pe_c;
    logic               unused_op_c;
    rule_t              wr_rule_c;

    logic [NRULES-1:0]  match_c;
    logic [NRULES-1:0]  last_c;
    logic [NRULES-1:0]  loop_fire_c;
    rule_kind_t         kind_c  [NRULES];
    logic [PCW-1:0]     raddr_c [NRULES];

    logic               fail_hit_c, pass_hit_c, jl_hit_c;
    logic [IW-1:0]      fail_idx_c, pass_idx_c, jl_idx_c;
    rule_kind_t         jl_kind_c;
    logic               jl_last_c;

    assign cont_pe_c   = (op_x[112:109] == SQI_CONT) && (op_x[96:95] == MAP_PE);
    assign unused_op_c = ^op_x[94:1];

    assign wr_rule_c = '{kind:    decode_kind(cfg_kind),
                         from_pc: cfg_from,
                         to_pc:   cfg_to,
                         target:  cfg_target,
                         count:   cfg_count};

    for (genvar g = 0; g < NRULES; g++) begin : g_rule
        ucode_chk_rule u_rule (
            .clk       (clk),
            .reset     (reset),
            .we        (cfg_we && (cfg_idx == IW'(g))),
            .wr_rule   (wr_rule_c),
            .pc_x      (pc_x),
            .pc_f      (pc_f),
            .cont_pe   (cont_pe_c),
            .cont_addr (op_x[108:97]),
            .loop_fire (loop_fire_c[g]),
            .match_c   (match_c[g]),
            .kind_c    (kind_c[g]),
            .redir_c   (raddr_c[g]),
            .last_c    (last_c[g])
        );
    end

    // Lowest matching index per class; scanning downward lets the lowest win.
    always_comb begin
        fail_hit_c = 1'b0;
        pass_hit_c = 1'b0;
        jl_hit_c   = 1'b0;
        fail_idx_c = '0;
        pass_idx_c = '0;
        jl_idx_c   = '0;
        for (int i = int'(NRULES) - 1; i >= 0; i--) begin
            if (match_c[i]) begin
                unique case (kind_c[i])
                    RK_FAIL: begin fail_hit_c = 1'b1; fail_idx_c = IW'(i); end
                    RK_PASS: begin pass_hit_c = 1'b1; pass_idx_c = IW'(i); end
                    RK_JUMP, RK_LOOP: begin jl_hit_c = 1'b1; jl_idx_c = IW'(i); end
                    default: ;
                endcase
            end
        end
    end

    assign jl_kind_c     = kind_c[jl_idx_c];
    assign jl_last_c     = last_c[jl_idx_c];
    assign retire_run_c  = retire && (state_q == ST_RUN);
    assign cyc_next_c    = cyc_q + LIMW'(1);
    assign timeout_hit_c = (state_q != ST_DONE) && (limit != '0) && (cyc_next_c >= limit);

    // Only the winning LOOP rule advances its counter, and never on a timeout cycle.
    always_comb begin
        loop_fire_c = '0;
        if (retire_run_c && !timeout_hit_c && !fail_hit_c && !pass_hit_c &&
            jl_hit_c && (jl_kind_c == RK_LOOP)) begin
            loop_fire_c[jl_idx_c] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_RUN;
            cyc_q       <= '0;
            redir_valid <= 1'b0;
            redir_pc    <= '0;
            ev_valid    <= 1'b0;
            ev_rule     <= '0;
            ev_kind     <= '0;
            done        <= 1'b0;
            pass        <= 1'b0;
            fail        <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            ev_valid <= 1'b0;
            unique case (state_q)
                ST_RUN, ST_REDIR: begin
                    cyc_q <= cyc_next_c;
                    if (timeout_hit_c) begin
                        timeout     <= 1'b1;
                        done        <= 1'b1;
                        redir_valid <= 1'b0;
                        state_q     <= ST_DONE;
                    end else if (state_q == ST_REDIR) begin
                        if (redir_ready) begin
                            redir_valid <= 1'b0;
                            state_q     <= ST_RUN;
                        end
                    end else if (retire) begin
                        if (fail_hit_c) begin
                            fail     <= 1'b1;
                            done     <= 1'b1;
                            ev_valid <= 1'b1;
                            ev_rule  <= fail_idx_c;
                            ev_kind  <= RK_FAIL;
                            state_q  <= ST_DONE;
                        end else if (pass_hit_c) begin
                            pass     <= 1'b1;
                            done     <= 1'b1;
                            ev_valid <= 1'b1;
                            ev_rule  <= pass_idx_c;
                            ev_kind  <= RK_PASS;
                            state_q  <= ST_DONE;
                        end else if (jl_hit_c) begin
                            // JUMP: event + redirect. LOOP: redirect until the last pass, then event.
                            if ((jl_kind_c == RK_JUMP) || jl_last_c) begin
                                ev_valid <= 1'b1;
                                ev_rule  <= jl_idx_c;
                                ev_kind  <= jl_kind_c;
                            end
                            if ((jl_kind_c == RK_JUMP) || !jl_last_c) begin
                                redir_valid <= 1'b1;
                                redir_pc    <= raddr_c[jl_idx_c];
                                state_q     <= ST_REDIR;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef UCODE_CHK_HIST_EN
    logic [PCW-1:0] hist_mem [8];
    logic [2:0]     hist_wp;

    // Newest entry sits just behind the write pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) hist_mem[i] <= '0;
            hist_wp <= '0;
            hist_pc <= '0;
        end else begin
            hist_pc <= hist_mem[hist_wp - 3'd1 - hist_idx];
            if (retire_run_c) begin
                hist_mem[hist_wp] <= pc_x;
                hist_wp           <= hist_wp + 3'd1;
            end
        end
    end
`else
    logic unused_hist_c;
    assign unused_hist_c = ^hist_idx;
    assign hist_pc       = '0;
`endif

endmodule

// File: tb/tb_ucode_chk_unit.sv
// Directed + randomized bench for ucode_chk_unit against a rule-level reference model.
module tb_ucode_chk_unit;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          retire = 1'b0;
    logic [11:0]   pc_x = '0, pc_f = '0;
    logic [112:1]  op_x = '0;
    logic          cfg_we = 1'b0;
    logic [4:0]    cfg_idx = '0;
    logic [2:0]    cfg_kind = '0;
    logic [11:0]   cfg_from = '0, cfg_to = '0, cfg_target = '0;
    logic [15:0]   cfg_count = '0;
    logic [31:0]   limit = '0;
    logic          redir_ready = 1'b0;
    logic [2:0]    hist_idx = '0;
    logic          redir_valid, ev_valid, done, pass, fail, timeout;
    logic [11:0]   redir_pc, hist_pc;
    logic [4:0]    ev_rule;
    logic [2:0]    ev_kind;

    ucode_chk_unit dut (
        .clk(clk), .reset(reset), .retire(retire), .pc_x(pc_x), .pc_f(pc_f), .op_x(op_x),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_kind(cfg_kind), .cfg_from(cfg_from),
        .cfg_to(cfg_to), .cfg_target(cfg_target), .cfg_count(cfg_count), .limit(limit),
        .redir_valid(redir_valid), .redir_pc(redir_pc), .redir_ready(redir_ready),
        .ev_valid(ev_valid), .ev_rule(ev_rule), .ev_kind(ev_kind), .done(done),
        .pass(pass), .fail(fail), .timeout(timeout), .hist_idx(hist_idx), .hist_pc(hist_pc)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: rule table, loop counts, and the expected outputs.
    int unsigned mk[32], mf[32], mt[32], mg[32], mc[32], mcnt[32];
    bit          m_redir = 1'b0, m_done = 1'b0;
    int unsigned m_cyc = 0;
    logic        e_rv = 0, e_ev = 0, e_done = 0, e_pass = 0, e_fail = 0, e_to = 0;
    logic [11:0] e_rpc = '0, e_hist = '0;
    logic [4:0]  e_rule = '0;
    logic [2:0]  e_kind = '0;
    logic [11:0] hist_q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit rule_hit(input int i);
        case (mk[i])
            1: return (32'(pc_x) == mf[i]) && (32'(pc_f) == mt[i]);
            2: return (op_x[112:109] == 4'd14) && (op_x[96:95] == 2'd0) && (32'(op_x[108:97]) == mf[i]);
            3, 4: return 32'(pc_x) == mf[i];
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [112:1] mk_op(input int sqi, input int addr, input int map);
        logic [112:1] o;
        o = '0;
        o[112:109] = 4'(sqi);
        o[108:97]  = 12'(addr);
        o[96:95]   = 2'(map);
        return o;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            mk[i] = 0; mf[i] = 0; mt[i] = 0; mg[i] = 0; mc[i] = 0; mcnt[i] = 0;
        end
        m_redir = 0; m_done = 0; m_cyc = 0;
        e_rv = 0; e_ev = 0; e_done = 0; e_pass = 0; e_fail = 0; e_to = 0;
        e_rpc = '0; e_hist = '0; e_rule = '0; e_kind = '0;
        hist_q.delete();
    endtask

    // Advance the model on the current inputs, clock once, compare every output.
    task automatic tick();
        bit was_run;
        int fi, pi, ji;
        int unsigned eff;
        if (reset) begin
            model_reset();
        end else begin
            fi = -1; pi = -1; ji = -1;
            e_ev = 0;
`ifdef UCODE_CHK_HIST_EN
            e_hist = (int'(hist_idx) < hist_q.size()) ? hist_q[hist_q.size() - 1 - int'(hist_idx)] : '0;
`else
            e_hist = '0;
`endif
            was_run = !m_done && !m_redir;
            if (!m_done) begin
                m_cyc++;
                if (limit != 0 && m_cyc >= limit) begin
                    e_to = 1; e_done = 1; e_rv = 0; m_done = 1; m_redir = 0;
                end else if (m_redir) begin
                    if (redir_ready) begin m_redir = 0; e_rv = 0; end
                end else if (retire) begin
                    for (int i = 31; i >= 0; i--) begin
                        if (rule_hit(i)) begin
                            if (mk[i] == 3) fi = i;
                            else if (mk[i] == 4) pi = i;
                            else ji = i;
                        end
                    end
                    if (fi >= 0) begin
                        e_fail = 1; e_done = 1; m_done = 1; e_ev = 1; e_rule = 5'(fi); e_kind = 3;
                    end else if (pi >= 0) begin
                        e_pass = 1; e_done = 1; m_done = 1; e_ev = 1; e_rule = 5'(pi); e_kind = 4;
                    end else if (ji >= 0 && mk[ji] == 1) begin
                        e_ev = 1; e_rule = 5'(ji); e_kind = 1;
                        e_rv = 1; e_rpc = 12'(mg[ji]); m_redir = 1;
                    end else if (ji >= 0) begin
                        mcnt[ji]++;
                        eff = (mc[ji] == 0) ? 1 : mc[ji];
                        if (mcnt[ji] < eff) begin
                            e_rv = 1; e_rpc = 12'(mf[ji]); m_redir = 1;
                        end else begin
                            e_ev = 1; e_rule = 5'(ji); e_kind = 2; mcnt[ji] = 0;
                        end
                    end
                end
            end
            if (was_run && retire) begin
                hist_q.push_back(pc_x);
                if (hist_q.size() > 8) void'(hist_q.pop_front());
            end
            if (cfg_we) begin
                mk[cfg_idx] = (cfg_kind > 4) ? 0 : 32'(cfg_kind);
                mf[cfg_idx] = 32'(cfg_from); mt[cfg_idx] = 32'(cfg_to);
                mg[cfg_idx] = 32'(cfg_target); mc[cfg_idx] = 32'(cfg_count);
                mcnt[cfg_idx] = 0;
            end
        end
        @(posedge clk); #1;
        chk("redir_valid", 64'(redir_valid), 64'(e_rv));
        chk("redir_pc", 64'(redir_pc), 64'(e_rpc));
        chk("ev_valid", 64'(ev_valid), 64'(e_ev));
        chk("ev_rule", 64'(ev_rule), 64'(e_rule));
        chk("ev_kind", 64'(ev_kind), 64'(e_kind));
        chk("done", 64'(done), 64'(e_done));
        chk("pass", 64'(pass), 64'(e_pass));
        chk("fail", 64'(fail), 64'(e_fail));
        chk("timeout", 64'(timeout), 64'(e_to));
        chk("hist_pc", 64'(hist_pc), 64'(e_hist));
    endtask

    task automatic wr(input int idx, input int kind, input int from, input int to,
                      input int tgt, input int cnt);
        cfg_we = 1; cfg_idx = 5'(idx); cfg_kind = 3'(kind); cfg_from = 12'(from);
        cfg_to = 12'(to); cfg_target = 12'(tgt); cfg_count = 16'(cnt);
        tick();
        cfg_we = 0;
    endtask

    task automatic ret(input int px, input int pf, input logic [112:1] op);
        retire = 1; pc_x = 12'(px); pc_f = 12'(pf); op_x = op;
        tick();
        retire = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        reset = 1; tick(); reset = 0;
    endtask

    task automatic handshake();
        redir_ready = 1; tick(); redir_ready = 0;
    endtask

    initial begin
        logic [112:1] cont226;
        logic [127:0] rnd_op;
        cont226 = mk_op(14, 226, 0);

        // Reset state
        idle(2);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_redir", 64'(redir_valid), 64'd0);
        reset = 0;

        // JUMP with stalled handshake
        wr(0, 1, 0, 1, 110, 0);
        ret(0, 1, '0);
        chk("jump_valid", 64'(redir_valid), 64'd1);
        chk("jump_pc", 64'(redir_pc), 64'd110);
        chk("jump_rule", 64'(ev_rule), 64'd0);
        idle(3);
        chk("jump_hold", 64'(redir_valid), 64'd1);
        handshake();
        chk("jump_drop", 64'(redir_valid), 64'd0);

        // LOOP count 3
        wr(2, 2, 226, 0, 0, 3);
        ret(300, 301, cont226);
        chk("loop1_pc", 64'(redir_pc), 64'd226);
        chk("loop1_ev", 64'(ev_valid), 64'd0);
        handshake();
        ret(300, 301, cont226);
        handshake();
        ret(300, 301, cont226);
        chk("loop3_ev", 64'(ev_kind), 64'd2);
        chk("loop3_rv", 64'(redir_valid), 64'd0);
        ret(300, 301, cont226);
        chk("loop_restart", 64'(redir_valid), 64'd1);
        handshake();

        // FAIL outranks a lower-index JUMP
        wr(5, 3, 869, 0, 0, 0);
        wr(1, 1, 869, 870, 55, 0);
        ret(869, 870, '0);
        chk("fail_flag", 64'(fail), 64'd1);
        chk("fail_rule", 64'(ev_rule), 64'd5);
        chk("fail_rv", 64'(redir_valid), 64'd0);
        ret(0, 1, '0);
        idle(3);

        // Cycle limit with an empty table
        do_reset();
        limit = 50;
        idle(49);
        chk("to_early", 64'(timeout), 64'd0);
        idle(1);
        chk("to_hit", 64'(timeout), 64'd1);
        chk("to_pass", 64'(pass), 64'd0);
        idle(2);
        limit = 0;
        do_reset();

        // Rewrite during a matching retire
        wr(0, 1, 40, 41, 100, 0);
        cfg_we = 1; cfg_idx = 0; cfg_kind = 1; cfg_from = 40; cfg_to = 41; cfg_target = 200;
        ret(40, 41, '0);
        cfg_we = 0;
        chk("wr_old", 64'(redir_pc), 64'd100);
        handshake();
        ret(40, 41, '0);
        chk("wr_new", 64'(redir_pc), 64'd200);
        handshake();

        // History buffer
        do_reset();
        for (int p = 10; p < 20; p++) ret(p, 0, '0);
        hist_idx = 0; tick();
`ifdef UCODE_CHK_HIST_EN
        chk("hist_new", 64'(hist_pc), 64'd19);
`endif
        hist_idx = 7; tick();
`ifdef UCODE_CHK_HIST_EN
        chk("hist_old", 64'(hist_pc), 64'd12);
`endif

        // Randomized traffic with periodic resets
        for (int n = 0; n < 4000; n++) begin
            reset = ($urandom_range(0, 399) == 0);
            if (reset) limit = ($urandom_range(0, 1) == 0) ? 32'd0 : 32'($urandom_range(40, 600));
            cfg_we = ($urandom_range(0, 15) == 0);
            cfg_idx = 5'($urandom_range(0, 31));
            cfg_kind = 3'($urandom_range(0, 7));
            if ((cfg_kind == 3 || cfg_kind == 4) && $urandom_range(0, 7) != 0) cfg_kind = 1;
            cfg_from = 12'($urandom_range(0, 7));
            cfg_to = 12'($urandom_range(0, 7));
            cfg_target = 12'($urandom);
            cfg_count = 16'($urandom_range(0, 4));
            retire = $urandom_range(0, 1) == 1;
            pc_x = 12'($urandom_range(0, 7));
            pc_f = 12'($urandom_range(0, 7));
            if ($urandom_range(0, 2) == 0) begin
                op_x = mk_op(14, $urandom_range(0, 7), 0);
            end else begin
                rnd_op = {$urandom, $urandom, $urandom, $urandom};
                op_x = rnd_op[111:0];
            end
            redir_ready = $urandom_range(0, 1) == 1;
            hist_idx = 3'($urandom_range(0, 7));
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
